// File: rtl/fetch_pred_reg.sv
// F-stage register and next-PC predictor: JXX/CALL predicted taken, else fall-through.
// Ports: clk, rst, F_stall, f_valid, f_icode, f_valC, f_valP, ras_flush -> FpredPC, pred_from_ras, ras_count. Optional RAS via `RAS_EN.
module fetch_pred_reg #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int          RAS_DEPTH = 8,
  parameter int          RAS_PTR_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 F_stall,
  input  logic                 f_valid,
  input  logic [3:0]           f_icode,
  input  logic [63:0]          f_valC,
  input  logic [63:0]          f_valP,
  input  logic                 ras_flush,
  output logic [63:0]          FpredPC,
  output logic                 pred_from_ras,
  output logic [RAS_PTR_W:0]   ras_count
);

  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;

  logic        is_jc;
  logic        pop;
  logic [63:0] ras_top;
  logic [63:0] pred_nxt;

  assign is_jc = (f_icode == I_JXX) || (f_icode == I_CALL);

`ifdef RAS_EN
  logic [63:0]          ras_mem [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] ptr;
  logic [RAS_PTR_W-1:0] ptr_inc;
  logic [RAS_PTR_W:0]   cnt;
  logic                 push;

  localparam logic [RAS_PTR_W:0] FULL = (RAS_PTR_W+1)'(RAS_DEPTH);

  // A flush in the same cycle as a call/ret cancels the RAS access.
  assign push    = f_valid && (f_icode == I_CALL) && !ras_flush;
  assign pop     = f_valid && (f_icode == I_RET) && !ras_flush
                   && (cnt != '0);
  assign ptr_inc = ptr + 1'b1;
  assign ras_top = ras_mem[ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (!F_stall) begin
      if (ras_flush) begin
        ptr <= '0;
        cnt <= '0;
      end else if (push) begin
        ptr <= ptr_inc;
        cnt <= (cnt == FULL) ? cnt : cnt + 1'b1;
      end else if (pop) begin
        ptr <= ptr - 1'b1;
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && !F_stall && push)
      ras_mem[ptr_inc] <= f_valP;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pred_from_ras <= 1'b0;
    else if (!F_stall)
      pred_from_ras <= pop;
  end

  assign ras_count = cnt;
`else
  logic unused_ras_flush;

  assign unused_ras_flush = ras_flush;
  assign pop              = 1'b0;
  assign ras_top          = 64'd0;
  assign pred_from_ras    = 1'b0;
  assign ras_count        = '0;
`endif

  always_comb begin
    pred_nxt = f_valP;
    unique case (1'b1)
      is_jc:   pred_nxt = f_valC;
      pop:     pred_nxt = ras_top;
      default: pred_nxt = f_valP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      FpredPC <= RESET_PC;
    else if (!F_stall && f_valid)
      FpredPC <= pred_nxt;
  end

endmodule

// File: tb/tb_fetch_pred_reg.sv
// Randomized + directed bench for fetch_pred_reg against a queue-based model.
// Works in both builds; RAS expectations follow `RAS_EN.
module tb_fetch_pred_reg;

  localparam logic [63:0] RPC = 64'h2;
  localparam int DEPTH = 8;
`ifdef RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        F_stall;
  logic        f_valid;
  logic [3:0]  f_icode;
  logic [63:0] f_valC;
  logic [63:0] f_valP;
  logic        ras_flush;
  logic [63:0] FpredPC;
  logic        pred_from_ras;
  logic [3:0]  ras_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_pred;
  logic        m_fr;
  logic [63:0] m_ras[$];

  always #5 clk = ~clk;

  fetch_pred_reg #(
    .RESET_PC(RPC), .RAS_DEPTH(DEPTH), .RAS_PTR_W(3)
  ) dut (
    .clk(clk), .rst(rst), .F_stall(F_stall),
    .f_valid(f_valid), .f_icode(f_icode),
    .f_valC(f_valC), .f_valP(f_valP),
    .ras_flush(ras_flush), .FpredPC(FpredPC),
    .pred_from_ras(pred_from_ras),
    .ras_count(ras_count)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic r, st, v,
                       input logic [3:0] ic,
                       input logic [63:0] vc, vp,
                       input logic fl);
    bit ras_fl;
    ras_fl = RAS_ON && fl;
    if (r) begin
      m_pred = RPC;
      m_fr   = 1'b0;
      m_ras.delete();
    end else if (!st) begin
      if (ras_fl) m_ras.delete();
      m_fr = 1'b0;
      if (v) begin
        if (ic == 4'h7 || ic == 4'h8) begin
          m_pred = vc;
          if (ic == 4'h8 && RAS_ON && !ras_fl) begin
            m_ras.push_back(vp);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
          end
        end else if (ic == 4'h9 && RAS_ON && !ras_fl
                     && m_ras.size() > 0) begin
          m_pred = m_ras.pop_back();
          m_fr   = 1'b1;
        end else begin
          m_pred = vp;
        end
      end
    end
  endtask

  task automatic cyc(input logic r, st, v,
                     input logic [3:0] ic,
                     input logic [63:0] vc, vp,
                     input logic fl);
    rst = r; F_stall = st; f_valid = v; f_icode = ic;
    f_valC = vc; f_valP = vp; ras_flush = fl;
    @(posedge clk);
    model(r, st, v, ic, vc, vp, fl);
    #1;
    chk("FpredPC", FpredPC, m_pred);
    chk("pred_from_ras", {63'd0, pred_from_ras}, {63'd0, m_fr});
    chk("ras_count", {60'd0, ras_count}, 64'(m_ras.size()));
  endtask

  initial begin
    logic [3:0] ic;
    m_pred = '0;
    m_fr   = 1'b0;
    // reset with active JXX on inputs
    cyc(1, 0, 1, 4'h7, 64'h100, 64'h20, 0);
    cyc(1, 0, 1, 4'h7, 64'h100, 64'h20, 0);
    chk("reset_pc", FpredPC, 64'h2);
    // jump then fall-through
    cyc(0, 0, 1, 4'h7, 64'h100, 64'h20, 0);
    chk("jxx_taken", FpredPC, 64'h100);
    cyc(0, 0, 1, 4'h6, 64'h0, 64'h22, 0);
    chk("opq_fall", FpredPC, 64'h22);
    // stall with CALL pending
    repeat (3) cyc(0, 1, 1, 4'h8, 64'h400, 64'h24, 1);
    cyc(0, 0, 1, 4'h8, 64'h400, 64'h24, 0);
    chk("stall_release", FpredPC, 64'h400);
    // RAS round trip
    cyc(1, 0, 0, 4'h0, 0, 0, 0);
    cyc(0, 0, 1, 4'h8, 64'h1000, 64'h30, 0);
    cyc(0, 0, 1, 4'h8, 64'h2000, 64'h50, 0);
    cyc(0, 0, 1, 4'h9, 64'h0, 64'h11, 0);
    cyc(0, 0, 1, 4'h9, 64'h0, 64'h12, 0);
    cyc(0, 0, 1, 4'h9, 64'h0, 64'h60, 0);
    chk("ret_empty", FpredPC, 64'h60);
    // overflow
    for (int k = 1; k <= 9; k++)
      cyc(0, 0, 1, 4'h8, 64'h5000, 64'(k * 16), 0);
    for (int k = 0; k < 9; k++)
      cyc(0, 0, 1, 4'h9, 64'h0, 64'h7770 + 64'(k), 0);
    // flush collision
    cyc(0, 0, 1, 4'h8, 64'h800, 64'h40, 0);
    cyc(0, 0, 1, 4'h8, 64'h900, 64'h44, 0);
    cyc(0, 0, 1, 4'h8, 64'h700, 64'h48, 1);
    chk("flush_call", FpredPC, 64'h700);
    cyc(0, 0, 1, 4'h9, 64'h0, 64'h4c, 0);
    chk("ret_after_flush", FpredPC, 64'h4c);
    // idle flush and idle hold
    cyc(0, 0, 1, 4'h8, 64'hA00, 64'h50, 0);
    cyc(0, 0, 0, 4'h9, 64'h0, 64'h54, 1);
    // randomized
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 5))
        0: ic = 4'h7;
        1, 2: ic = 4'h8;
        3, 4: ic = 4'h9;
        default: ic = 4'($urandom_range(0, 15));
      endcase
      cyc($urandom_range(0, 60) == 0,
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 4) != 0,
          ic,
          {$urandom, $urandom},
          {$urandom, $urandom},
          $urandom_range(0, 15) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
